rastreador_caminho: RTL and testbench

RASTREADOR_CAMINHO -- requirements
Module: rastreador_caminho

---
 rtl/rastreador_caminho_pkg.sv | 43 ++++
 rtl/rastreador_caminho.sv | 156 +++++++++++++++
 tb/tb_rastreador_caminho.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rastreador_caminho_pkg.sv
// ----------------------------------------------------------------------------
// rastreador_caminho_pkg
//
// Purpose: definitions shared by every block that touches the predecessor
// memory. The path tracer reads this memory and the path search engine
// writes it. Keeping the word layout and the tracer state encoding here
// means both sides always agree on them.
//
// Predecessor word layout (DATA_WIDTH bits):
//   [PRED_LSB +: ADDR_WIDTH]   predecessor node index
//   [DATA_WIDTH-1]             valid flag (1 = a predecessor exists)
//
// Contents:
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH  default word and address widths
//   PRED_LSB                         LSB of the predecessor field
//   valid_bit_index()                index of the valid flag for a word width
//   pred_field_width()               width of the predecessor field
//   state_t                          tracer FSM state encoding
// ----------------------------------------------------------------------------
package rastreador_caminho_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int PRED_LSB       = 0;

    function automatic int valid_bit_index(input int data_width);
        return data_width - 1;
    endfunction

    function automatic int pred_field_width(input int addr_width);
        return addr_width;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EMIT = 3'd1,
        ST_READ = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/rastreador_caminho.sv
// ----------------------------------------------------------------------------
// rastreador_caminho
//
// Purpose: walks the predecessor memory from a destination node back to a
// source node. It emits each visited node on a valid/ready stream, ordered
// from destination to source. The trace aborts with an error pulse in two
// cases: a node has no valid predecessor, or the walk reaches 2**ADDR_WIDTH
// hops (this means the memory contains a cycle).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start_i         trace request, accepted only while idle
//   src_addr_i      source node, latched on an accepted start
//   dst_addr_i      destination node, latched on an accepted start
//   read_en_o       read strobe to the predecessor RAM read port
//   read_addr_o     read address (current node)
//   data_i          RAM read data, valid one cycle after read_en_o
//   node_valid_o    node_o/last_o hold a path node
//   node_ready_i    consumer accepts the node
//   node_o          path node index
//   last_o          node_o is the source (final node)
//   busy_o          tracer is not idle
//   done_o          one-cycle pulse after the final node is accepted
//   error_o         one-cycle pulse when the trace aborts
// ----------------------------------------------------------------------------
module rastreador_caminho
    import rastreador_caminho_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    output logic                  read_en_o,
    output logic [ADDR_WIDTH-1:0] read_addr_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  node_valid_o,
    input  logic                  node_ready_i,
    output logic [ADDR_WIDTH-1:0] node_o,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int VALID_BIT = valid_bit_index(DATA_WIDTH);
    localparam int PRED_W    = pred_field_width(ADDR_WIDTH);

    // A trace that reaches 2**ADDR_WIDTH hops has visited more nodes than
    // exist, so the predecessor chain must contain a loop.
    localparam logic [ADDR_WIDTH:0] HOP_LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] HOP_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cur, cur_nx;
    logic [ADDR_WIDTH-1:0] src, src_nx;
    logic [ADDR_WIDTH:0]   hops, hops_nx;
    logic [ADDR_WIDTH:0]   hop_inc;
    logic                  at_src;

    // The bits between the predecessor field and the valid flag are
    // reserved in the word format and deliberately ignored.
    logic unused_data;
    assign unused_data = ^data_i[DATA_WIDTH-2:ADDR_WIDTH];

    assign hop_inc = hops + HOP_ONE;
    assign at_src  = (cur == src);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cur   <= '0;
            src   <= '0;
            hops  <= '0;
        end else begin
            state <= state_nx;
            cur   <= cur_nx;
            src   <= src_nx;
            hops  <= hops_nx;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        src_nx   = src;
        hops_nx  = hops;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    src_nx   = src_addr_i;
                    cur_nx   = dst_addr_i;
                    hops_nx  = '0;
                    state_nx = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (node_ready_i) begin
                    state_nx = at_src ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (!data_i[VALID_BIT]) begin
                    state_nx = ST_ERR;
                end else if (hop_inc == HOP_LIMIT) begin
                    state_nx = ST_ERR;
                end else begin
                    cur_nx   = data_i[PRED_LSB +: PRED_W];
                    hops_nx  = hop_inc;
                    state_nx = ST_EMIT;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state alone. Reset therefore forces every
    // output to 0 at once. Node and address fields read as 0 whenever they
    // are not qualified.
    always_comb begin
        read_en_o    = 1'b0;
        read_addr_o  = '0;
        node_valid_o = 1'b0;
        node_o       = '0;
        last_o       = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        error_o      = 1'b0;
        case (state)
            ST_IDLE: busy_o = 1'b0;
            ST_EMIT: begin
                node_valid_o = 1'b1;
                node_o       = cur;
                last_o       = at_src;
            end
            ST_READ: begin
                read_en_o   = 1'b1;
                read_addr_o = cur;
            end
            ST_DONE: done_o  = 1'b1;
            ST_ERR:  error_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rastreador_caminho.sv
module tb_rastreador_caminho;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam logic [DW-1:0] V = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic          read_en;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] mem_q = '0;
    logic          node_valid;
    logic          node_ready = 1'b1;
    logic [AW-1:0] node;
    logic          last;
    logic          busy;
    logic          done;
    logic          err;

    rastreador_caminho #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .read_en_o    (read_en),
        .read_addr_o  (read_addr),
        .data_i       (mem_q),
        .node_valid_o (node_valid),
        .node_ready_i (node_ready),
        .node_o       (node),
        .last_o       (last),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (err)
    );

    always #5 clk = ~clk;

    // Predecessor RAM model with 1-cycle read latency
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (read_en) mem_q <= mem[read_addr];

    // Stream monitor: logs accepted nodes, reads, pulses and stall violations
    int  acc_nodes[$];
    bit  acc_last[$];
    int  read_addrs[$];
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  stall_viol = 0;
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic [AW-1:0] prev_n = '0;
    logic          prev_l = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (node_valid && node_ready) begin
                acc_nodes.push_back(int'(node));
                acc_last.push_back(last);
            end
            if (read_en) read_addrs.push_back(int'(read_addr));
            if (done) done_cnt <= done_cnt + 1;
            if (err)  err_cnt  <= err_cnt + 1;
            if (prev_v && !prev_r &&
                !(node_valid && node == prev_n && last == prev_l))
                stall_viol <= stall_viol + 1;
            prev_v <= node_valid;
            prev_r <= node_ready;
            prev_n <= node;
            prev_l <= last;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input int s, input int d);
        @(posedge clk); #1;
        src_addr = AW'(s);
        dst_addr = AW'(d);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done || err) break;
        end
        if (k == limit) check({name, " timeout"}, 32'd1, 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        int src;
        int dst;
        int n;
        int nodes[4];
        bit done;
        bit err;
        int reads;
    } vec_t;

    vec_t tbl[7];

    task automatic set_vec(input int i, input int s, input int d, input int n,
                           input int a, input int b, input int c,
                           input bit dn, input bit er, input int rd);
        tbl[i].src = s; tbl[i].dst = d; tbl[i].n = n;
        tbl[i].nodes[0] = a; tbl[i].nodes[1] = b; tbl[i].nodes[2] = c; tbl[i].nodes[3] = 0;
        tbl[i].done = dn; tbl[i].err = er; tbl[i].reads = rd;
    endtask

    int bn, br, bd, be, bs;
    bit rnd_stop;

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        mem[5] = V | 32'd3;
        mem[3] = V | 32'd1;
        mem[2] = V | 32'd6;
        mem[6] = V | 32'd2;
        mem[8] = V | 32'd4;
        mem[4] = 32'd1;   // valid flag clear, non-zero payload

        set_vec(0, 1, 5, 3, 5, 3, 1, 1, 0, 2);
        set_vec(1, 7, 7, 1, 7, 0, 0, 1, 0, 0);
        set_vec(2, 0, 4, 1, 4, 0, 0, 0, 1, 1);
        set_vec(3, 1, 3, 2, 3, 1, 0, 1, 0, 1);
        set_vec(4, 3, 5, 2, 5, 3, 0, 1, 0, 1);
        set_vec(5, 0, 8, 2, 8, 4, 0, 0, 1, 2);
        set_vec(6, 5, 5, 1, 5, 0, 0, 1, 0, 0);

        // Reset state
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst outputs", {read_en, node_valid, last, done, err, node, read_addr}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Latency on the basic chain
        node_ready = 1'b1;
        launch(1, 5);
        @(negedge clk);
        check("lat c1 valid", 32'(node_valid), 1);
        check("lat c1 node", 32'(node), 5);
        check("lat c1 last", 32'(last), 0);
        @(negedge clk);
        check("lat read_en", 32'(read_en), 1);
        check("lat read_addr", 32'(read_addr), 5);
        check("lat read valid", 32'(node_valid), 0);
        @(negedge clk);
        check("lat wait read_en", 32'(read_en), 0);
        check("lat wait busy", 32'(busy), 1);
        @(negedge clk);
        check("lat c4 valid", 32'(node_valid), 1);
        check("lat c4 node", 32'(node), 3);
        wait_end("lat", 50);

        // src == dst: done pulse at cycle 2
        launch(7, 7);
        @(negedge clk);
        check("same c1 node", {node_valid, last, 22'd0, node}, {1'b1, 1'b1, 22'd0, 10'd7});
        @(negedge clk);
        check("same c2 done", 32'(done), 1);
        @(negedge clk);
        check("same c3 done", 32'(done), 0);
        check("same c3 busy", 32'(busy), 0);

        // Table-driven traces
        for (int t = 0; t < 7; t++) begin
            bn = acc_nodes.size(); br = read_addrs.size(); bd = done_cnt; be = err_cnt;
            launch(tbl[t].src, tbl[t].dst);
            wait_end($sformatf("vec%0d", t), 100);
            check($sformatf("vec%0d nodes", t), 32'(acc_nodes.size() - bn), 32'(tbl[t].n));
            for (int k = 0; k < tbl[t].n && bn + k < acc_nodes.size(); k++) begin
                check($sformatf("vec%0d node%0d", t, k), 32'(acc_nodes[bn+k]), 32'(tbl[t].nodes[k]));
                check($sformatf("vec%0d last%0d", t, k), 32'(acc_last[bn+k]),
                      32'(tbl[t].done && (k == tbl[t].n - 1)));
            end
            check($sformatf("vec%0d reads", t), 32'(read_addrs.size() - br), 32'(tbl[t].reads));
            for (int k = 0; k < tbl[t].reads && br + k < read_addrs.size(); k++)
                check($sformatf("vec%0d raddr%0d", t, k), 32'(read_addrs[br+k]), 32'(tbl[t].nodes[k]));
            check($sformatf("vec%0d done", t), 32'(done_cnt - bd), 32'(tbl[t].done));
            check($sformatf("vec%0d err", t), 32'(err_cnt - be), 32'(tbl[t].err));
            check($sformatf("vec%0d busy", t), 32'(busy), 0);
        end

        // Cycle in memory: abort after 2**AW hops
        bn = acc_nodes.size(); br = read_addrs.size(); bd = done_cnt; be = err_cnt;
        launch(9, 2);
        wait_end("loop", 5000);
        check("loop err", 32'(err_cnt - be), 1);
        check("loop done", 32'(done_cnt - bd), 0);
        check("loop reads", 32'(read_addrs.size() - br), 32'(1 << AW));
        check("loop nodes", 32'(acc_nodes.size() - bn), 32'(1 << AW));
        check("loop busy", 32'(busy), 0);

        // Deterministic stall: node held stable with ready low
        node_ready = 1'b0;
        launch(1, 5);
        repeat (3) begin
            @(negedge clk);
            check("stall hold", {node_valid, last, 20'd0, node}, {1'b1, 1'b0, 20'd0, 10'd5});
        end
        #1 node_ready = 1'b1;
        wait_end("stall", 50);

        // Random ready with an ignored mid-trace start
        bn = acc_nodes.size(); bd = done_cnt; be = err_cnt; bs = stall_viol;
        rnd_stop = 1'b0;
        fork
            begin
                for (int c = 0; c < 400 && !rnd_stop; c++) begin
                    @(posedge clk); #1;
                    node_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                launch(1, 5);
                repeat (4) @(negedge clk);
                check("rnd busy mid", 32'(busy), 1);
                @(posedge clk); #1;
                src_addr = AW'(0); dst_addr = AW'(4); start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                wait_end("rnd", 300);
                rnd_stop = 1'b1;
            end
        join
        node_ready = 1'b1;
        check("rnd nodes", 32'(acc_nodes.size() - bn), 3);
        for (int k = 0; k < 3 && bn + k < acc_nodes.size(); k++)
            check($sformatf("rnd node%0d", k), 32'(acc_nodes[bn+k]), 32'(k == 0 ? 5 : (k == 1 ? 3 : 1)));
        check("rnd stall viol", 32'(stall_viol - bs), 0);
        check("rnd done", 32'(done_cnt - bd), 1);
        check("rnd err", 32'(err_cnt - be), 0);

        // Reset while in WAIT, then a fresh trace
        launch(1, 5);
        repeat (3) @(negedge clk);
        check("pre-rst wait", {busy, node_valid, read_en}, 3'b100);
        rst = 1'b1;
        #1;
        check("mid rst busy", 32'(busy), 0);
        check("mid rst outputs", {read_en, node_valid, last, done, err, node, read_addr}, 0);
        @(posedge clk); #1 rst = 1'b0;
        bn = acc_nodes.size(); bd = done_cnt; be = err_cnt;
        launch(1, 3);
        wait_end("post rst", 50);
        check("post rst nodes", 32'(acc_nodes.size() - bn), 2);
        if (acc_nodes.size() - bn == 2) begin
            check("post rst node0", 32'(acc_nodes[bn]), 3);
            check("post rst node1", 32'(acc_nodes[bn+1]), 1);
        end
        check("post rst done", 32'(done_cnt - bd), 1);
        check("post rst err", 32'(err_cnt - be), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
